// File: rtl/mtc_ppa_pkg.sv
// Shared types and helpers for the pointer-controlled arbitration wrapper.
package mtc_ppa_pkg;

  typedef enum logic [1:0] {StIdle, StIssue, StCollect, StOutput} state_e;

  // Helpers take vectors zero-extended to this width; WIDTH_N must not exceed it.
  localparam int unsigned MaxWidth = 64;

  function automatic int unsigned popcount(input logic [MaxWidth-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MaxWidth; i++) begin
      if (v[i]) cnt++;
    end
    return cnt;
  endfunction

  function automatic logic is_onehot(input logic [MaxWidth-1:0] v);
    return popcount(v) == 1;
  endfunction

endpackage

// File: rtl/mtc_ppa_ptr_calc.sv
// Fallback pointer: one above the highest granted bit, wrapping to bit 0;
// holds the current pointer when nothing was granted.
module mtc_ppa_ptr_calc #(
  parameter int unsigned WIDTH_N = 2
) (
  input  logic [WIDTH_N-1:0] gnt,
  input  logic [WIDTH_N-1:0] ptr,
  output logic [WIDTH_N-1:0] ptr_next
);

  always_comb begin
    ptr_next = ptr;
    // Ascending scan: the last hit is the most-significant set bit.
    for (int i = 0; i < WIDTH_N; i++) begin
      if (gnt[i]) begin
        ptr_next = (i == WIDTH_N - 1) ? WIDTH_N'(1) : (WIDTH_N'(1) << (i + 1));
      end
    end
  end

endmodule

// File: rtl/mtc_ppa_ptr_ctrl.sv
// Request capture, priority-pointer issue and grant merge around an external
// arbitration core; one transaction in flight, all handshake outputs registered.
module mtc_ppa_ptr_ctrl
  import mtc_ppa_pkg::*;
#(
  parameter int unsigned WIDTH_N  = 2,
  parameter int unsigned AMOUNT_M = 1,
  localparam int unsigned CntW    = $clog2(AMOUNT_M + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH_N-1:0]          req_i,
  input  logic                        req_vld_i,
  output logic                        req_rdy_o,
  output logic [WIDTH_N-1:0]          arb_req_o,
  output logic [WIDTH_N-1:0]          arb_ptr_o,
  output logic                        arb_vld_o,
  input  logic                        arb_rdy_i,
  input  logic [AMOUNT_M*WIDTH_N-1:0] arb_gnt_i,
  input  logic                        arb_gnt_vld_i,
  output logic                        arb_gnt_rdy_o,
  input  logic [WIDTH_N-1:0]          ptr_next_i,
  input  logic                        ptr_next_vld_i,
  output logic [WIDTH_N-1:0]          gnt_o,
  output logic [CntW-1:0]             gnt_cnt_o,
  output logic                        gnt_vld_o,
  input  logic                        gnt_rdy_i,
  output logic                        err_o
);

  state_e              state_q;
  logic [WIDTH_N-1:0]  req_q, ptr_q, gnt_q, side_q;
  logic [CntW-1:0]     cnt_q;
  logic                side_vld_q, err_q;
  logic                req_rdy_q, arb_vld_q, gnt_rdy_q, gnt_vld_q;

  logic [WIDTH_N-1:0]  merged, ptr_fallback;
  logic                overlap, stray, side_bad, use_side;

  always_comb begin
    merged  = '0;
    overlap = 1'b0;
    for (int i = 0; i < AMOUNT_M; i++) begin
      overlap = overlap | (|(merged & arb_gnt_i[i*WIDTH_N +: WIDTH_N]));
      merged  = merged | arb_gnt_i[i*WIDTH_N +: WIDTH_N];
    end
  end

  assign stray    = |(merged & ~req_q);
  assign side_bad = ptr_next_vld_i && !is_onehot(MaxWidth'(ptr_next_i));
  assign use_side = side_vld_q && is_onehot(MaxWidth'(side_q));

  mtc_ppa_ptr_calc #(
    .WIDTH_N (WIDTH_N)
  ) u_ptr_calc (
    .gnt      (gnt_q),
    .ptr      (ptr_q),
    .ptr_next (ptr_fallback)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      req_q      <= '0;
      ptr_q      <= WIDTH_N'(1);
      gnt_q      <= '0;
      cnt_q      <= '0;
      side_q     <= '0;
      side_vld_q <= 1'b0;
      err_q      <= 1'b0;
      req_rdy_q  <= 1'b1;
      arb_vld_q  <= 1'b0;
      gnt_rdy_q  <= 1'b0;
      gnt_vld_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A zero request vector is consumed without starting a transaction.
          if (req_vld_i && (req_i != '0)) begin
            req_q     <= req_i;
            req_rdy_q <= 1'b0;
            arb_vld_q <= 1'b1;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          if (arb_rdy_i) begin
            arb_vld_q <= 1'b0;
            gnt_rdy_q <= 1'b1;
            state_q   <= StCollect;
          end
        end
        StCollect: begin
          if (arb_gnt_vld_i) begin
            gnt_q      <= merged;
            cnt_q      <= CntW'(popcount(MaxWidth'(merged)));
            side_q     <= ptr_next_i;
            side_vld_q <= ptr_next_vld_i;
            if (stray || overlap || side_bad) err_q <= 1'b1;
            gnt_rdy_q  <= 1'b0;
            gnt_vld_q  <= 1'b1;
            state_q    <= StOutput;
          end
        end
        StOutput: begin
          if (gnt_rdy_i) begin
            ptr_q     <= use_side ? side_q : ptr_fallback;
            gnt_vld_q <= 1'b0;
            req_rdy_q <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_rdy_o     = req_rdy_q;
  assign arb_req_o     = req_q;
  assign arb_ptr_o     = ptr_q;
  assign arb_vld_o     = arb_vld_q;
  assign arb_gnt_rdy_o = gnt_rdy_q;
  assign gnt_o         = gnt_q;
  assign gnt_cnt_o     = cnt_q;
  assign gnt_vld_o     = gnt_vld_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_mtc_ppa_ptr_ctrl.sv
// Self-checking bench for mtc_ppa_ptr_ctrl with WIDTH_N=8, AMOUNT_M=2.
module tb_mtc_ppa_ptr_ctrl;

  localparam int unsigned W = 8;
  localparam int unsigned M = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] req_i;
  logic         req_vld_i;
  logic         req_rdy_o;
  logic [W-1:0] arb_req_o, arb_ptr_o;
  logic         arb_vld_o, arb_rdy_i;
  logic [M*W-1:0] arb_gnt_i;
  logic         arb_gnt_vld_i, arb_gnt_rdy_o;
  logic [W-1:0] ptr_next_i;
  logic         ptr_next_vld_i;
  logic [W-1:0] gnt_o;
  logic [1:0]   gnt_cnt_o;
  logic         gnt_vld_o, gnt_rdy_i, err_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mtc_ppa_ptr_ctrl #(
    .WIDTH_N  (W),
    .AMOUNT_M (M)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_i          (req_i),
    .req_vld_i      (req_vld_i),
    .req_rdy_o      (req_rdy_o),
    .arb_req_o      (arb_req_o),
    .arb_ptr_o      (arb_ptr_o),
    .arb_vld_o      (arb_vld_o),
    .arb_rdy_i      (arb_rdy_i),
    .arb_gnt_i      (arb_gnt_i),
    .arb_gnt_vld_i  (arb_gnt_vld_i),
    .arb_gnt_rdy_o  (arb_gnt_rdy_o),
    .ptr_next_i     (ptr_next_i),
    .ptr_next_vld_i (ptr_next_vld_i),
    .gnt_o          (gnt_o),
    .gnt_cnt_o      (gnt_cnt_o),
    .gnt_vld_o      (gnt_vld_o),
    .gnt_rdy_i      (gnt_rdy_i),
    .err_o          (err_o)
  );

  typedef struct {
    bit           rst;
    logic [W-1:0] req;
    logic [W-1:0] g0, g1;
    logic [W-1:0] pn;
    logic         pv;
    int           arb_stall, out_stall;
    logic [W-1:0] exp_ptr;
    logic [W-1:0] exp_gnt;
    logic [1:0]   exp_cnt;
    logic         exp_err;
  } row_t;

  typedef struct {
    logic [W-1:0] gnt;
    logic [1:0]   cnt;
    logic         err;
  } out_t;

  row_t rows[11];
  out_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_req_rdy", 32'(req_rdy_o), 1);
    chk("rst_arb_vld", 32'(arb_vld_o), 0);
    chk("rst_gnt_rdy", 32'(arb_gnt_rdy_o), 0);
    chk("rst_gnt_vld", 32'(gnt_vld_o), 0);
    chk("rst_gnt", 32'(gnt_o), 0);
    chk("rst_cnt", 32'(gnt_cnt_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_ptr", 32'(arb_ptr_o), 32'h01);
    chk("rst_arb_req", 32'(arb_req_o), 0);
  endtask

  task automatic run_row(input row_t r);
    out_t e;
    int n;
    if (r.rst) do_reset();
    chk("idle_req_rdy", 32'(req_rdy_o), 1);
    req_i = r.req;
    req_vld_i = 1'b1;
    tick();
    req_vld_i = 1'b0;
    chk("arb_vld_lat", 32'(arb_vld_o), 1);
    chk("arb_req", 32'(arb_req_o), 32'(r.req));
    chk("arb_ptr", 32'(arb_ptr_o), 32'(r.exp_ptr));
    chk("issue_req_rdy", 32'(req_rdy_o), 0);
    for (int s = 0; s < r.arb_stall; s++) begin
      tick();
      chk("arb_hold_vld", 32'(arb_vld_o), 1);
      chk("arb_hold_req", 32'(arb_req_o), 32'(r.req));
      chk("arb_hold_ptr", 32'(arb_ptr_o), 32'(r.exp_ptr));
      chk("arb_hold_req_rdy", 32'(req_rdy_o), 0);
    end
    arb_rdy_i = 1'b1;
    tick();
    arb_rdy_i = 1'b0;
    chk("collect_gnt_rdy", 32'(arb_gnt_rdy_o), 1);
    chk("collect_arb_vld", 32'(arb_vld_o), 0);
    arb_gnt_i = {r.g1, r.g0};
    ptr_next_i = r.pn;
    ptr_next_vld_i = r.pv;
    arb_gnt_vld_i = 1'b1;
    exp_q.push_back('{gnt: r.exp_gnt, cnt: r.exp_cnt, err: r.exp_err});
    tick();
    arb_gnt_vld_i = 1'b0;
    ptr_next_vld_i = 1'b0;
    ptr_next_i = '0;
    chk("output_gnt_rdy", 32'(arb_gnt_rdy_o), 0);
    n = 0;
    while (!gnt_vld_o && n < 8) begin
      tick();
      n++;
    end
    chk("gnt_vld_lat", 32'(n), 0);
    e = exp_q.pop_front();
    chk("gnt", 32'(gnt_o), 32'(e.gnt));
    chk("gnt_cnt", 32'(gnt_cnt_o), 32'(e.cnt));
    chk("err", 32'(err_o), 32'(e.err));
    for (int s = 0; s < r.out_stall; s++) begin
      tick();
      chk("out_hold_vld", 32'(gnt_vld_o), 1);
      chk("out_hold_gnt", 32'(gnt_o), 32'(e.gnt));
      chk("out_hold_cnt", 32'(gnt_cnt_o), 32'(e.cnt));
      chk("out_hold_req_rdy", 32'(req_rdy_o), 0);
    end
    gnt_rdy_i = 1'b1;
    tick();
    gnt_rdy_i = 1'b0;
    chk("done_gnt_vld", 32'(gnt_vld_o), 0);
    chk("done_req_rdy", 32'(req_rdy_o), 1);
  endtask

  initial begin
    reset = 1'b1;
    req_i = '0;
    req_vld_i = 1'b0;
    arb_rdy_i = 1'b0;
    arb_gnt_i = '0;
    arb_gnt_vld_i = 1'b0;
    ptr_next_i = '0;
    ptr_next_vld_i = 1'b0;
    gnt_rdy_i = 1'b0;

    //          rst req    g0     g1     pn     pv  as os  ptr    gnt    cnt err
    rows[0]  = '{1, 8'h96, 8'h02, 8'h04, 8'h00, 0, 0, 0, 8'h01, 8'h06, 2, 0};
    rows[1]  = '{0, 8'h90, 8'h80, 8'h10, 8'h02, 1, 2, 3, 8'h08, 8'h90, 2, 0};
    rows[2]  = '{0, 8'h81, 8'h80, 8'h00, 8'h00, 0, 0, 0, 8'h02, 8'h80, 1, 0};
    rows[3]  = '{0, 8'h0F, 8'h01, 8'h08, 8'h10, 1, 0, 1, 8'h01, 8'h09, 2, 0};
    rows[4]  = '{0, 8'h30, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h10, 8'h00, 0, 0};
    rows[5]  = '{0, 8'h60, 8'h20, 8'h00, 8'h00, 0, 0, 0, 8'h10, 8'h20, 1, 0};
    rows[6]  = '{1, 8'h96, 8'h01, 8'h00, 8'h00, 0, 0, 0, 8'h01, 8'h01, 1, 1};
    rows[7]  = '{0, 8'h0C, 8'h04, 8'h08, 8'h00, 0, 0, 0, 8'h02, 8'h0C, 2, 1};
    rows[8]  = '{1, 8'h06, 8'h02, 8'h00, 8'h03, 1, 0, 0, 8'h01, 8'h02, 1, 1};
    rows[9]  = '{0, 8'h0C, 8'h08, 8'h00, 8'h00, 0, 0, 0, 8'h04, 8'h08, 1, 1};
    rows[10] = '{1, 8'h06, 8'h02, 8'h02, 8'h00, 0, 0, 0, 8'h01, 8'h02, 1, 1};

    for (int i = 0; i < 11; i++) run_row(rows[i]);

    // Zero request is swallowed: no issue, still ready.
    req_i = 8'h00;
    req_vld_i = 1'b1;
    tick();
    req_vld_i = 1'b0;
    chk("zero_arb_vld", 32'(arb_vld_o), 0);
    chk("zero_req_rdy", 32'(req_rdy_o), 1);
    tick();
    chk("zero_arb_vld2", 32'(arb_vld_o), 0);
    chk("zero_ptr", 32'(arb_ptr_o), 32'h04);

    // Reset while in COLLECT aborts the transaction.
    req_i = 8'h96;
    req_vld_i = 1'b1;
    tick();
    req_vld_i = 1'b0;
    arb_rdy_i = 1'b1;
    tick();
    arb_rdy_i = 1'b0;
    chk("abort_in_collect", 32'(arb_gnt_rdy_o), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_arb_vld", 32'(arb_vld_o), 0);
    chk("abort_gnt_vld", 32'(gnt_vld_o), 0);
    chk("abort_gnt_rdy", 32'(arb_gnt_rdy_o), 0);
    chk("abort_ptr", 32'(arb_ptr_o), 32'h01);
    chk("abort_req_rdy", 32'(req_rdy_o), 1);
    chk("abort_arb_req", 32'(arb_req_o), 0);
    chk("abort_err", 32'(err_o), 0);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("abort_quiet_vld", 32'(gnt_vld_o | arb_vld_o), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
